// File: rtl/qpsk_tx_scheduler.sv
// qpsk_tx_scheduler: builds one transmit frame (preamble, sync word, payload
// dibits, guard interval) from a byte stream and hands the QPSK modulator one
// symbol per mod_req slot. Also owns the modulator carrier tuning word, which
// is only ever updated at the start of a frame.
module qpsk_tx_scheduler #(
    parameter int          PREAMBLE_SYMS = 32,
    parameter logic [15:0] SYNC_WORD     = 16'hD391,
    parameter int          GUARD_SYMS    = 8,
    parameter logic [31:0] FCW_DEFAULT   = 32'h028F5C29
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic [31:0] cfg_fcw,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        mod_req,
    output logic [1:0]  symbol_in,
    output logic        symbol_en,
    output logic [31:0] fcw,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_PAYLOAD,
        ST_GUARD
    } state_t;

    localparam logic [7:0] PRE_LAST   = 8'(PREAMBLE_SYMS - 1);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_SYMS - 1);
    localparam logic [7:0] SYNC_LAST  = 8'd7;

    state_t      r_state;
    state_t      w_state_next;

    // Slot counter shared by preamble, sync and guard phases.
    logic [7:0]  r_cnt;

    // Byte being serialised (shifted left two bits per dibit) and its spare.
    logic [7:0]  r_cur;
    logic        r_cur_valid;
    logic        r_cur_last;
    logic [1:0]  r_dib_idx;
    logic [7:0]  r_nxt;
    logic        r_nxt_valid;
    logic        r_nxt_last;
    logic        r_last_seen;

    // Registered modulator-facing outputs.
    logic [1:0]  r_symbol_in;
    logic        r_symbol_en;
    logic [31:0] r_fcw;
    logic        r_frame_done;
    logic        r_underrun;

    logic        w_accept;
    logic        w_pay_emit;
    logic        w_byte_end;
    logic        w_refill;
    logic [15:0] w_sync_shift;
    logic [1:0]  w_sym_next;
    logic        w_sym_en_next;
    logic        w_frame_done_next;
    logic        w_underrun_next;

    // Sync dibit k sits in the top two bits after shifting left by 2k.
    assign w_sync_shift = SYNC_WORD << {r_cnt[2:0], 1'b0};

    // A payload dibit goes out on this slot only if a byte is already in cur.
    assign w_pay_emit = (r_state == ST_PAYLOAD) && mod_req && r_cur_valid;
    assign w_byte_end = w_pay_emit && (r_dib_idx == 2'd3);
    // A byte accepted on the very slot cur drains is passed straight to cur.
    assign w_refill   = r_nxt_valid || w_accept;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; everything except the frame start waits for a slot.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (tx_enable && s_valid) begin
                    w_state_next = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (mod_req && (r_cnt == PRE_LAST)) begin
                    w_state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (mod_req && (r_cnt == SYNC_LAST)) begin
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (mod_req) begin
                    if (!r_cur_valid) begin
                        w_state_next = ST_GUARD;
                    end else if ((r_dib_idx == 2'd3) && (r_cur_last || !w_refill)) begin
                        w_state_next = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (mod_req && (r_cnt == GUARD_LAST)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode: handshake, busy, and the values the output registers take.
    always_comb begin
        busy              = (r_state != ST_IDLE);
        s_ready           = ((r_state == ST_SYNC) || (r_state == ST_PAYLOAD))
                            && !r_nxt_valid && !r_last_seen;
        w_accept          = s_valid && s_ready;
        w_sym_next        = r_symbol_in;
        w_sym_en_next     = r_symbol_en;
        w_frame_done_next = 1'b0;
        w_underrun_next   = 1'b0;
        if (mod_req) begin
            case (r_state)
                ST_PREAMBLE: begin
                    w_sym_next    = r_cnt[0] ? 2'b10 : 2'b00;
                    w_sym_en_next = 1'b1;
                end
                ST_SYNC: begin
                    w_sym_next    = w_sync_shift[15:14];
                    w_sym_en_next = 1'b1;
                end
                ST_PAYLOAD: begin
                    if (r_cur_valid) begin
                        w_sym_next    = r_cur[7:6];
                        w_sym_en_next = 1'b1;
                        if ((r_dib_idx == 2'd3) && !r_cur_last && !w_refill) begin
                            w_underrun_next = 1'b1;
                        end
                    end else begin
                        // Nothing to send on the first payload slot.
                        w_sym_next      = 2'b00;
                        w_sym_en_next   = 1'b0;
                        w_underrun_next = 1'b1;
                    end
                end
                ST_GUARD: begin
                    w_sym_next    = 2'b00;
                    w_sym_en_next = 1'b0;
                    if (r_cnt == GUARD_LAST) begin
                        w_frame_done_next = 1'b1;
                    end
                end
                default: begin
                    w_sym_next    = r_symbol_in;
                    w_sym_en_next = r_symbol_en;
                end
            endcase
        end
    end

    // Slot counter: restarts on every phase change, advances once per slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (w_state_next != r_state) begin
            r_cnt <= 8'd0;
        end else if (mod_req && ((r_state == ST_PREAMBLE) || (r_state == ST_SYNC)
                                 || (r_state == ST_GUARD))) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Byte buffers: serialise cur, refill it from nxt, park new bytes in nxt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur       <= 8'd0;
            r_cur_valid <= 1'b0;
            r_cur_last  <= 1'b0;
            r_dib_idx   <= 2'd0;
            r_nxt       <= 8'd0;
            r_nxt_valid <= 1'b0;
            r_nxt_last  <= 1'b0;
            r_last_seen <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_cur_valid <= 1'b0;
            r_cur_last  <= 1'b0;
            r_dib_idx   <= 2'd0;
            r_nxt_valid <= 1'b0;
            r_nxt_last  <= 1'b0;
            r_last_seen <= 1'b0;
        end else begin
            if (w_pay_emit) begin
                if (w_byte_end) begin
                    r_dib_idx <= 2'd0;
                    if (r_cur_last) begin
                        r_cur_valid <= 1'b0;
                    end else if (r_nxt_valid) begin
                        r_cur       <= r_nxt;
                        r_cur_last  <= r_nxt_last;
                        r_nxt_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_cur      <= s_data;
                        r_cur_last <= s_last;
                    end else begin
                        r_cur_valid <= 1'b0;
                    end
                end else begin
                    r_cur     <= {r_cur[5:0], 2'b00};
                    r_dib_idx <= r_dib_idx + 2'd1;
                end
            end
            if (w_accept) begin
                if (s_last) begin
                    r_last_seen <= 1'b1;
                end
                if (!r_cur_valid) begin
                    r_cur       <= s_data;
                    r_cur_valid <= 1'b1;
                    r_cur_last  <= s_last;
                end else if (!w_byte_end) begin
                    r_nxt       <= s_data;
                    r_nxt_valid <= 1'b1;
                    r_nxt_last  <= s_last;
                end
            end
        end
    end

    // Modulator outputs, status pulses and the per-frame carrier word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_symbol_in  <= 2'b00;
            r_symbol_en  <= 1'b0;
            r_fcw        <= FCW_DEFAULT;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_symbol_in  <= w_sym_next;
            r_symbol_en  <= w_sym_en_next;
            r_frame_done <= w_frame_done_next;
            r_underrun   <= w_underrun_next;
            if ((r_state == ST_IDLE) && (w_state_next == ST_PREAMBLE)) begin
                r_fcw <= cfg_fcw;
            end
        end
    end

    assign symbol_in  = r_symbol_in;
    assign symbol_en  = r_symbol_en;
    assign fcw        = r_fcw;
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule

// File: doc/qpsk_tx_scheduler.md
Name: qpsk_tx_scheduler

Overview:
Frame-level symbol scheduler for the QPSK modulator. It accepts payload bytes on a valid/ready byte stream and builds a frame: preamble, sync word, payload dibits, then a guard interval. It issues exactly one symbol per modulator `mod_req` pulse on `symbol_in`/`symbol_en`. It also owns the modulator's carrier `fcw` and changes it only between frames.

Parameters:
- PREAMBLE_SYMS, 32, number of preamble symbols (alternating 2'b00 / 2'b10, starting with 2'b00); legal range 2..255.
- SYNC_WORD, 16'hD391, sync word, sent as 8 dibits, MSB dibit first.
- GUARD_SYMS, 8, number of symbol slots with symbol_en=0 after the payload; legal range 1..255.
- FCW_DEFAULT, 32'h028F5C29, fcw value at reset.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- tx_enable, input, 1, permits a new frame to start.
- cfg_fcw, input, 32, carrier tuning word; sampled at frame start.
- s_data, input, 8, payload byte.
- s_valid, input, 1, s_data valid.
- s_last, input, 1, marks the final byte of the frame; qualified by s_valid.
- s_ready, output, 1, byte accepted when s_valid && s_ready.
- mod_req, input, 1, one-cycle symbol-slot strobe from the modulator.
- symbol_in, output, 2, dibit to the modulator.
- symbol_en, output, 1, symbol valid to the modulator.
- fcw, output, 32, tuning word to the modulator.
- busy, output, 1, high in any state other than IDLE.
- frame_done, output, 1, one-cycle pulse at the end of the guard interval.
- underrun, output, 1, one-cycle pulse when the payload runs dry.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE; symbol_in=2'b00; symbol_en=0; fcw=FCW_DEFAULT; s_ready=0; busy=0; frame_done=0; underrun=0.
  - Byte buffers are cleared and counters are zeroed.
  - Reset mid-frame aborts the frame with no frame_done pulse.
- Storage: shift register `cur` (byte being sent, with a dibit index 0..3) and one-entry `nxt` buffer with a valid flag.
- s_ready = (state is SYNC or PAYLOAD) && !nxt_valid && !last_seen.
  - last_seen is set when a byte with s_last=1 is accepted; it is cleared in IDLE.
- States. All transitions except IDLE->PREAMBLE happen only in a cycle where mod_req=1. symbol_in/symbol_en are registered and update in the cycle after mod_req, then hold until the next mod_req.
  - IDLE:
    - If tx_enable && s_valid: latch fcw<=cfg_fcw, clear counters, go to PREAMBLE.
    - No byte is consumed here.
    - symbol_en stays 0.
  - PREAMBLE:
    - On each mod_req, emit 2'b00 (even count) or 2'b10 (odd count) with symbol_en=1.
    - After PREAMBLE_SYMS emissions, go to SYNC.
  - SYNC:
    - On each mod_req, emit dibit SYNC_WORD[15-2k -: 2] for k=0..7.
    - After the 8th emission, go to PAYLOAD.
  - PAYLOAD:
    - On each mod_req, emit cur[7:6], then [5:4], [3:2], [1:0].
    - When a byte's last dibit is emitted:
      - if that byte carried last, go to GUARD;
      - else if nxt_valid, move nxt to cur and clear nxt_valid;
      - else pulse underrun and go to GUARD.
    - On the first PAYLOAD mod_req, cur must already hold a byte. If it is empty, pulse underrun, go to GUARD, and emit no payload dibit.
    - Loading: if cur is empty, an accepted byte goes to cur, otherwise to nxt. An accept and a move nxt->cur in the same cycle go to nxt after the move (no loss).
  - GUARD:
    - symbol_en=0 and symbol_in=2'b00 on each slot.
    - After GUARD_SYMS mod_req pulses, pulse frame_done for one cycle and go to IDLE.
    - Back-to-back frames are allowed from the following cycle.
- mod_req outside a frame (IDLE) is ignored.
- Dropping tx_enable mid-frame has no effect; the frame completes.
- Symbol count per frame = PREAMBLE_SYMS + 8 + 4*N + GUARD_SYMS.
- fcw does not change between frame start and IDLE, regardless of cfg_fcw.

Test Plan:
1. Reset: hold reset=0 with toggling inputs -> symbol_en=0, fcw=FCW_DEFAULT, s_ready=0, busy=0.
2. PREAMBLE_SYMS=4, single byte 0xB4 with s_last, mod_req every 100 clocks:
   - symbols 00,10,00,10, then 11,01,00,11,10,01,00,01, then 10,11,01,00, all with symbol_en=1;
   - then 8 slots with symbol_en=0;
   - then frame_done high for exactly 1 cycle; busy low the next cycle.
3. Three-byte frame 0x00,0xFF,0x1B with s_valid held continuously:
   - s_ready never high while nxt is full;
   - payload dibits are 00x4, 11x4, 00,01,10,11;
   - no underrun.
4. Underrun: first byte 0x5A without s_last, source then stalls -> dibits 01,01,10,10, then underrun pulse, guard slots, frame_done.
5. fcw: cfg_fcw=32'h1000_0000 at frame start, changed to 32'h2000_0000 mid-frame -> fcw stays 32'h1000_0000 until the next frame start.
6. Reset asserted during SYNC -> immediate reset values, no frame_done. A frame after release starts again with the preamble.
